demux_1_to_n_stream: RTL and testbench

Registered 1-to-N stream demultiplexer: the counterpart of the generic N-to-1 mux. It accepts one valid/ready input stream tagged with a destination select and steers each word into one of N independent output channels. Each channel has a one-entry holding register, so back-pressure on one channel stalls only traffic addressed to it. It sits at fan-out points such as the command distributors and per-lane dispatch in the datapath library.

---
 rtl/datapath_pkg.sv | 16 +
 rtl/demux_channel_reg.sv | 43 ++++
 rtl/demux_1_to_n_stream.sv | 88 ++++++++
 tb/tb_demux_1_to_n_stream.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - shared helpers for the stream mux/demux datapath blocks
package datapath_pkg;

    // Width of a channel-select field for n channels; a single channel still needs one bit
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Increment value, clamping at the all-ones value of a width-bit counter
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
        logic [31:0] max_v;
        max_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value >= max_v) ? max_v : value + 32'd1;
    endfunction

endpackage

// File: rtl/demux_channel_reg.sv
// rtl/demux_channel_reg.sv - one-entry valid/ready holding register for one output channel
module demux_channel_reg #(
    parameter int M = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [M-1:0] load_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] out_data
);

    logic         valid_q, valid_d;
    logic [M-1:0] data_q, data_d;

    // Load wins over drain so a simultaneous drain+load keeps the slot full
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Holding register; data keeps its last value after a drain
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/demux_1_to_n_stream.sv
// rtl/demux_1_to_n_stream.sv - registered 1-to-N stream demultiplexer with per-channel holding registers
module demux_1_to_n_stream
    import datapath_pkg::*;
#(
    parameter int N            = 2,
    parameter int M            = 1,
    parameter int SELECT_WIDTH = sel_width(N),
    parameter int COUNT_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [M-1:0]            in_data,
    input  logic [SELECT_WIDTH-1:0] in_select,
    output logic [N-1:0]            out_valid,
    input  logic [N-1:0]            out_ready,
    output logic [M-1:0]            out_data [N-1:0],
    output logic                    bad_select,
    output logic [COUNT_WIDTH-1:0]  drop_count
);

    logic                   sel_in_range;
    logic [N-1:0]           sel_onehot;
    logic                   slot_free;
    logic                   accept;
    logic                   drop;
    logic [N-1:0]           load;
    logic                   bad_select_q;
    logic [COUNT_WIDTH-1:0] drop_count_q, drop_count_d;

    // Decode the destination; out-of-range selects map to no channel
    always_comb begin
        sel_in_range = (32'(in_select) < 32'(N));
        sel_onehot   = '0;
        for (int k = 0; k < N; k++) begin
            sel_onehot[k] = sel_in_range && (32'(in_select) == 32'(k));
        end
    end

    // Ready depends only on the addressed channel, never on in_valid or in_data
    always_comb begin
        slot_free = |(sel_onehot & (~out_valid | out_ready));
        in_ready  = !reset && enable && (sel_in_range ? slot_free : 1'b1);
        accept    = in_valid && in_ready;
        drop      = accept && !sel_in_range;
        load      = accept ? sel_onehot : '0;
    end

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_chan
            demux_channel_reg #(.M(M)) u_chan (
                .clk       (clk),
                .reset     (reset),
                .load      (load[g]),
                .load_data (in_data),
                .out_valid (out_valid[g]),
                .out_ready (out_ready[g]),
                .out_data  (out_data[g])
            );
        end
    endgenerate

    // Next value of the saturating drop counter
    always_comb begin
        drop_count_d = drop_count_q;
        if (drop) begin
            drop_count_d = COUNT_WIDTH'(sat_inc(32'(drop_count_q), COUNT_WIDTH));
        end
    end

    // Drop pulse and counter register, both visible the cycle after the drop
    always_ff @(posedge clk) begin
        if (reset) begin
            bad_select_q <= 1'b0;
            drop_count_q <= '0;
        end else begin
            bad_select_q <= drop;
            drop_count_q <= drop_count_d;
        end
    end

    assign bad_select = bad_select_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_demux_1_to_n_stream.sv
// tb/tb_demux_1_to_n_stream.sv - randomized self-checking bench for demux_1_to_n_stream
module tb_demux_1_to_n_stream;

    localparam int N  = 3;
    localparam int M  = 8;
    localparam int SW = 2;
    localparam int CW = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          in_valid;
    logic          in_ready;
    logic [M-1:0]  in_data;
    logic [SW-1:0] in_select;
    logic [N-1:0]  out_valid;
    logic [N-1:0]  out_ready;
    logic [M-1:0]  out_data [N-1:0];
    logic          bad_select;
    logic [CW-1:0] drop_count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: each channel is a slot that is either empty or holds a word
    bit       m_full [N];
    logic [7:0] m_last [N];
    bit       m_bad;
    int       m_drops;

    always #5 clk = ~clk;

    demux_1_to_n_stream #(.N(N), .M(M), .SELECT_WIDTH(SW), .COUNT_WIDTH(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_select  (in_select),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .bad_select (bad_select),
        .drop_count (drop_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit exp_ready();
        int s;
        s = int'(in_select);
        if (reset || !enable) return 1'b0;
        if (s >= N) return 1'b1;
        return !m_full[s] || out_ready[s];
    endfunction

    // Compare all outputs with the model mid-cycle, then advance one clock and update the model
    task automatic step();
        bit acc;
        int s;
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            check($sformatf("out_valid[%0d]", k), 32'(out_valid[k]), 32'(m_full[k]));
            check($sformatf("out_data[%0d]", k), 32'(out_data[k]), 32'(m_last[k]));
        end
        check("in_ready", 32'(in_ready), 32'(exp_ready()));
        check("bad_select", 32'(bad_select), 32'(m_bad));
        check("drop_count", 32'(drop_count), 32'(m_drops));
        acc = in_valid && exp_ready();
        s   = int'(in_select);
        @(posedge clk);
        if (reset) begin
            for (int k = 0; k < N; k++) begin
                m_full[k] = 1'b0;
                m_last[k] = 8'h00;
            end
            m_bad   = 1'b0;
            m_drops = 0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (m_full[k] && out_ready[k]) m_full[k] = 1'b0;
            end
            m_bad = acc && (s >= N);
            if (acc && s < N) begin
                m_full[s] = 1'b1;
                m_last[s] = in_data;
            end
            if (m_bad && m_drops < CMAX) m_drops++;
        end
        #1;
    endtask

    task automatic send(input logic [1:0] sel, input logic [7:0] data);
        in_valid  = 1'b1;
        in_select = sel;
        in_data   = data;
        step();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        step();
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            m_full[k] = 1'b0;
            m_last[k] = 8'h00;
        end
        m_bad = 1'b0;
        m_drops = 0;
        reset = 1'b1; enable = 1'b1; in_valid = 1'b1; in_select = 2'd0;
        in_data = 8'hFF; out_ready = 3'b111;
        @(posedge clk); #1;
        step();
        step();
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_drop_count", 32'(drop_count), 32'h0);
        reset = 1'b0;

        // Single word into channel 2
        send(2'd2, 8'hA5);
        check("a5_valid", 32'(out_valid), 32'b100);
        check("a5_data", 32'(out_data[2]), 32'hA5);
        idle();
        check("a5_drained", 32'(out_valid), 32'b000);

        // Back-pressure on channel 1, other channels unaffected
        out_ready = 3'b101;
        send(2'd1, 8'h11);
        send(2'd1, 8'h22);
        send(2'd1, 8'h22);
        check("bp_hold", 32'(out_data[1]), 32'h11);
        send(2'd0, 8'h33);
        check("bp_side", 32'(out_data[0]), 32'h33);
        out_ready = 3'b111;
        send(2'd1, 8'h22);
        check("bp_swap", 32'(out_data[1]), 32'h22);
        idle();

        // Full-throughput stream on channel 0
        for (int i = 1; i <= 8; i++) begin
            send(2'd0, 8'(i));
            check("stream_data", 32'(out_data[0]), 32'(i));
        end
        idle();
        idle();

        // Out-of-range drops and saturation
        for (int i = 0; i < 5; i++) begin
            send(2'd3, 8'hEE);
            check("drop_pulse", 32'(bad_select), 32'h1);
            idle();
        end
        check("drop_sat", 32'(drop_count), CMAX);

        // Enable low blocks input but not draining; then reset mid-transfer
        out_ready = 3'b000;
        send(2'd0, 8'h44);
        enable = 1'b0;
        send(2'd1, 8'h55);
        check("en_block", 32'(out_valid), 32'b001);
        out_ready = 3'b001;
        send(2'd1, 8'h55);
        check("en_drain", 32'(out_valid), 32'b000);
        enable = 1'b1;
        out_ready = 3'b000;
        send(2'd2, 8'h66);
        reset = 1'b1;
        send(2'd1, 8'h77);
        check("rst_mid_valid", 32'(out_valid), 32'h0);
        check("rst_mid_data", 32'(out_data[2]), 32'h0);
        reset = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(0, 59) == 0);
            enable    = ($urandom_range(0, 7) != 0);
            in_valid  = $urandom_range(0, 1);
            in_select = 2'($urandom_range(0, 3));
            in_data   = 8'($urandom);
            out_ready = 3'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
